// File: rtl/irq_pkg.sv
// Shared level encodings, FSM state type and level-mask helpers for the nested
// interrupt controller.
package irq_pkg;

    localparam int unsigned NUM_LVL = 3;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    typedef enum logic {ST_IDLE, ST_REQ} irq_state_e;

    function automatic logic [NUM_LVL-1:0] lvl_onehot(input logic [1:0] lvl);
        unique case (lvl)
            LVL_1:   lvl_onehot = 3'b001;
            LVL_2:   lvl_onehot = 3'b010;
            LVL_3:   lvl_onehot = 3'b100;
            default: lvl_onehot = 3'b000;
        endcase
    endfunction

    // Levels strictly above lvl; only these may preempt the current service level.
    function automatic logic [NUM_LVL-1:0] above_mask(input logic [1:0] lvl);
        unique case (lvl)
            LVL_NONE: above_mask = 3'b111;
            LVL_1:    above_mask = 3'b110;
            LVL_2:    above_mask = 3'b100;
            default:  above_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-set-bit encoder: 3-bit level vector to 2-bit level index, 0 when empty.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_LVL-1:0] i_vec,
    output logic [1:0]         o_idx
);

    always_comb begin
        if (i_vec[2]) begin
            o_idx = LVL_3;
        end else if (i_vec[1]) begin
            o_idx = LVL_2;
        end else if (i_vec[0]) begin
            o_idx = LVL_1;
        end else begin
            o_idx = LVL_NONE;
        end
    end

endmodule

// File: rtl/irq_nest_ctrl.sv
// Three-level nested interrupt controller: edge-latched requests, presentation FSM
// and in-service tracking so only a higher level can preempt the one being served.
module irq_nest_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_LVL-1:0] inter,
    input  logic               int_en,
    input  logic [NUM_LVL-1:0] int_mask,
    output logic               irq,
    output logic [1:0]         irq_level,
    output logic [31:0]        irq_vec,
    input  logic               irq_ack,
    input  logic               eret,
    output logic [NUM_LVL-1:0] pending,
    output logic [NUM_LVL-1:0] running
);

    irq_state_e         r_state, w_state_d;
    logic [1:0]         r_level, w_level_d;
    logic [NUM_LVL-1:0] r_inter_q, r_pending, r_running;
    logic [NUM_LVL-1:0] w_pending_d, w_running_d, w_elig;
    logic [1:0]         w_cur, w_best;
    logic               w_ack;

    irq_prio_enc u_cur_enc (
        .i_vec (r_running),
        .o_idx (w_cur)
    );

    assign w_elig = r_pending & int_mask & {NUM_LVL{int_en}} & above_mask(w_cur);

    irq_prio_enc u_best_enc (
        .i_vec (w_elig),
        .o_idx (w_best)
    );

    // An ack only counts while a level is actually being presented.
    assign w_ack = irq_ack && (r_state == ST_REQ);

    // A fresh edge on the acked level re-arms it, so set is applied after clear.
    assign w_pending_d = (r_pending & ~(w_ack ? lvl_onehot(r_level) : '0)) |
                         (inter & ~r_inter_q);
    assign w_running_d = (r_running & ~(eret ? lvl_onehot(w_cur) : '0)) |
                         (w_ack ? lvl_onehot(r_level) : '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= ST_IDLE;
            r_level   <= LVL_NONE;
            r_inter_q <= '0;
            r_pending <= '0;
            r_running <= '0;
        end else begin
            r_state   <= w_state_d;
            r_level   <= w_level_d;
            r_inter_q <= inter;
            r_pending <= w_pending_d;
            r_running <= w_running_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        unique case (r_state)
            ST_IDLE: begin
                if (w_best != LVL_NONE) begin
                    w_state_d = ST_REQ;
                    w_level_d = w_best;
                end
            end
            ST_REQ: begin
                if (irq_ack || (w_best == LVL_NONE)) begin
                    w_state_d = ST_IDLE;
                    w_level_d = LVL_NONE;
                end else begin
                    w_level_d = w_best;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_level_d = LVL_NONE;
            end
        endcase
    end

    always_comb begin
        irq       = 1'b0;
        irq_level = LVL_NONE;
        if (r_state == ST_REQ) begin
            irq       = 1'b1;
            irq_level = r_level;
        end
        irq_vec = VEC_BASE + {30'd0, irq_level} * VEC_STRIDE;
    end

    assign pending = r_pending;
    assign running = r_running;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Scoreboard bench for irq_nest_ctrl: a level/stack reference model predicts each
// post-edge output set, a monitor compares after every rising edge.
module tb_irq_nest_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  inter;
    logic        int_en;
    logic [2:0]  int_mask;
    logic        irq_ack;
    logic        eret;
    logic        irq;
    logic [1:0]  irq_level;
    logic [31:0] irq_vec;
    logic [2:0]  pending;
    logic [2:0]  running;

    irq_nest_ctrl #(
        .VEC_BASE   (32'h0000_0800),
        .VEC_STRIDE (32'h0000_0080)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .inter     (inter),
        .int_en    (int_en),
        .int_mask  (int_mask),
        .irq       (irq),
        .irq_level (irq_level),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .eret      (eret),
        .pending   (pending),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [1:0]  lvl;
        logic [31:0] vec;
        logic [2:0]  pend;
        logic [2:0]  run;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pending flags, in-service levels as a stack, presented level.
    logic [2:0] m_pend    = '0;
    logic [2:0] m_inter_q = '0;
    int         q_run[$];
    int         m_pres    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] run_bits();
        logic [2:0] rb = '0;
        foreach (q_run[k]) rb[q_run[k]-1] = 1'b1;
        return rb;
    endfunction

    // Drive one cycle of inputs at a falling edge and predict the state after the next rise.
    task automatic step(input logic [2:0] in, input logic en, input logic [2:0] msk,
                        input logic ack, input logic er);
        int         cur;
        int         best;
        logic [2:0] np;
        exp_t       e;
        inter = in; int_en = en; int_mask = msk; irq_ack = ack; eret = er;
        cur  = (q_run.size() > 0) ? q_run[q_run.size()-1] : 0;
        best = 0;
        for (int l = 1; l <= 3; l++) begin
            if (m_pend[l-1] && msk[l-1] && en && (l > cur)) best = l;
        end
        np = m_pend;
        if ((m_pres != 0) && ack) np[m_pres-1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in[i] && !m_inter_q[i]) np[i] = 1'b1;
        end
        if (er && (q_run.size() > 0)) void'(q_run.pop_back());
        if ((m_pres != 0) && ack) begin
            q_run.push_back(m_pres);
            m_pres = 0;
        end else begin
            m_pres = best;
        end
        m_pend    = np;
        m_inter_q = in;
        e.irq  = (m_pres != 0);
        e.lvl  = 2'(m_pres);
        e.vec  = 32'h800 + 32'(m_pres) * 32'h80;
        e.pend = m_pend;
        e.run  = run_bits();
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
    endtask

    task automatic raise(input logic [2:0] in);
        step(in, 1'b1, 3'b111, 1'b0, 1'b0);
    endtask

    task automatic ack_it();
        step(3'b000, 1'b1, 3'b111, 1'b1, 1'b0);
    endtask

    task automatic eret_it();
        step(3'b000, 1'b1, 3'b111, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("irq",       {31'd0, irq},       {31'd0, e.irq});
                check("irq_level", {30'd0, irq_level}, {30'd0, e.lvl});
                check("irq_vec",   irq_vec,            e.vec);
                check("pending",   {29'd0, pending},   {29'd0, e.pend});
                check("running",   {29'd0, running},   {29'd0, e.run});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        clr = 1'b0; inter = '0; int_en = 1'b0; int_mask = '0; irq_ack = 1'b0; eret = 1'b0;
        #1;
        check("rst_irq",   {31'd0, irq},     32'd0);
        check("rst_vec",   irq_vec,          32'h800);
        check("rst_run",   {29'd0, running}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // Single level 1 round trip.
        raise(3'b001);
        idle(1);
        check("l1_vec", irq_vec, 32'h880);
        ack_it();
        check("l1_run", {29'd0, running}, 32'h1);
        eret_it();
        idle(1);

        // Nesting 1 -> 2 -> 3 then unwind.
        raise(3'b001); idle(1); ack_it();
        raise(3'b010); idle(1);
        check("nest_l2", {30'd0, irq_level}, 32'd2);
        ack_it();
        raise(3'b100); idle(1); ack_it();
        check("nest_run7", {29'd0, running}, 32'h7);
        eret_it(); eret_it(); eret_it();
        check("nest_run0", {29'd0, running}, 32'h0);
        idle(1);

        // No downward preemption while level 3 in service.
        raise(3'b100); idle(1); ack_it();
        raise(3'b001); idle(2);
        check("nodown_irq", {31'd0, irq}, 32'd0);
        eret_it();
        idle(1);
        check("nodown_lvl", {30'd0, irq_level}, 32'd1);
        ack_it(); eret_it();

        // Upgrade while presenting.
        raise(3'b001); idle(1);
        raise(3'b100); idle(1);
        check("upg_vec", irq_vec, 32'h980);
        ack_it();
        check("upg_pend", {29'd0, pending}, 32'h1);
        eret_it(); idle(1); ack_it(); eret_it();

        // Masking and global disable.
        step(3'b010, 1'b1, 3'b101, 1'b0, 1'b0);
        step(3'b000, 1'b1, 3'b101, 1'b0, 1'b0);
        step(3'b000, 1'b1, 3'b101, 1'b0, 1'b0);
        check("mask_irq", {31'd0, irq}, 32'd0);
        step(3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
        check("unmask_lvl", {30'd0, irq_level}, 32'd2);
        step(3'b000, 1'b0, 3'b111, 1'b0, 1'b0);
        check("dis_irq", {31'd0, irq}, 32'd0);
        idle(1); ack_it(); eret_it();

        // Same-level edge during ack: the level stays pending.
        raise(3'b001); step(3'b000, 1'b1, 3'b111, 1'b0, 1'b0);
        step(3'b001, 1'b1, 3'b111, 1'b1, 1'b0);
        eret_it(); idle(2); ack_it(); eret_it();

        // Async reset mid-service with a request presented.
        raise(3'b001); idle(1); ack_it();
        raise(3'b010); idle(1); ack_it();
        raise(3'b100); idle(1);
        #2;
        clr = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq},       32'd0);
        check("arst_lvl", {30'd0, irq_level}, 32'd0);
        check("arst_vec", irq_vec,            32'h800);
        check("arst_run", {29'd0, running},   32'd0);
        check("arst_pnd", {29'd0, pending},   32'd0);
        inter = '0; irq_ack = 1'b0; eret = 1'b0;
        m_pend = '0; m_inter_q = '0; m_pres = 0; q_run.delete(); sb.delete();
        @(negedge clk);
        clr = 1'b1;

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            logic [2:0] r_in;
            logic       r_en;
            logic [2:0] r_msk;
            logic       r_ack;
            logic       r_er;
            for (int b = 0; b < 3; b++) r_in[b] = ($urandom_range(0, 5) == 0);
            r_en  = ($urandom_range(0, 15) != 0);
            r_msk = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            r_ack = (m_pres != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            r_er  = ($urandom_range(0, 7) == 0);
            step(r_in, r_en, r_msk, r_ack, r_er);
        end
        idle(2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_nest_ctrl.md
# irq_nest_ctrl

Three-level nested, prioritised interrupt controller between the external interrupt lines (`inter1..3`) and the MIPS CPU core in `top`. It latches request edges, presents the highest eligible request to the CPU with its handler vector, and tracks which levels are in service so a higher level preempts a lower one, never the reverse. The in-service bits drive the `inter_running1..3` board outputs.

## Interface
Parameters:
- `VEC_BASE`, 32'h0000_0800: handler vector base address.
- `VEC_STRIDE`, 32'h0000_0080: byte spacing between per-level handlers.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `inter`  in  3  raw request lines; bit0 = level 1, bit2 = level 3 (highest).
- `int_en`  in  1  global interrupt enable (CPU status IE bit).
- `int_mask`  in  3  per-level enable, 1 = enabled.
- `irq`  out  1  interrupt request to the CPU.
- `irq_level`  out  2  level presented; 0 = none, 1..3.
- `irq_vec`  out  32  handler address for `irq_level`.
- `irq_ack`  in  1  CPU accepts the presented interrupt this cycle (EPC saved, pipeline flushed).
- `eret`  in  1  CPU retires an `eret`; ends the current in-service level.
- `pending`  out  3  latched, not-yet-accepted requests.
- `running`  out  3  in-service levels; map to `inter_running1..3`.

## Operation
- Edge capture: `inter` registered into `inter_q`; rising edge (`inter & ~inter_q`) sets `pending[i]`. Requests must be held high ≥1 `clk` cycle. Level re-assertion while pending: no effect (one pending per level).
- Current level `cur` = index of highest set bit of `running`, 0 if none.
- Eligible set `elig = pending & int_mask & {3{int_en}}`, restricted to levels > `cur`. `best` = highest eligible level.
- FSM, two states:
  - IDLE: `irq`=0, `irq_level`=0. If `best`≠0 → REQ, latching `best`.
  - REQ: `irq`=1, `irq_level`=latched level, `irq_vec`=`VEC_BASE + irq_level*VEC_STRIDE`. Each cycle without ack, relatch to current `best` (a higher arrival upgrades the presented level). If `best`=0 (masked/disabled) → IDLE. On `irq_ack`: clear `pending[level]`, set `running[level]`, → IDLE.
- `eret`: clear highest set bit of `running`; ignored when `running`=0. Next cycle the lower preempted level is again `cur`; any pending level above it is re-presented.
- `irq_ack` while in IDLE: ignored.
- Simultaneous `eret` and `irq_ack`: both applied (eret clears old highest bit, ack sets presented bit).
- Simultaneous new edge and ack on same level: set wins, level stays pending.
- Vector width arithmetic: 32-bit, wrap-around ignored.

## Timing
- Reset (`clr`=0, async): `pending`=0, `running`=0, `inter_q`=0, FSM=IDLE, `irq`=0, `irq_level`=0, `irq_vec`=`VEC_BASE`.
- Latency: `inter` rises before edge N → `pending` set after N → `irq` high after N+1 (2 cycles).
- After `irq_ack` at edge M: `irq` low after M; next request (if any) earliest after M+1.
- After `eret` at edge M: re-presentation earliest `irq` high after M+1.
- Reset mid-REQ or mid-service: everything cleared immediately; no request survives.
- All outputs registered or decoded from registers only; no combinational path from inputs to `irq`.

## Structure
- Package `irq_pkg`: level encodings (`LVL_NONE`=0..`LVL_3`=3), FSM state enum (`ST_IDLE`, `ST_REQ`), `NUM_LVL`=3.
- One sub-module `irq_prio_enc`: 3-bit vector → 2-bit highest-set index; instantiated for `cur` and `best`.

## Test plan
- Single level 1: `inter[0]` high 1 cycle, `int_en`=1, mask=3'b111 → `irq`=1, `irq_level`=1, `irq_vec`=32'h880 two cycles later; ack → `running`=3'b001, `pending`=0; `eret` → `running`=0.
- Nesting 1→2→3: raise 1, ack; raise 2 → presented while `running`=001, ack → 011; raise 3, ack → 111; three `eret`s → 011, 001, 000.
- No downward preemption: `running`=100, raise 1 → `pending`=001, `irq`=0; `eret` → `irq`=1, level 1 next cycle.
- Upgrade in REQ: level 1 presented, no ack, raise 3 → `irq_level` becomes 3, `irq_vec`=32'h980; ack → `running`=100, `pending`=001.
- Masking: `int_mask`=3'b101, raise 2 → `irq` stays 0, `pending`=010; set mask bit → presented 2 cycles later at most; `int_en`=0 in REQ → IDLE.
- Async reset while `running`=011 and REQ active → all outputs zero immediately, `irq_vec`=`VEC_BASE`.
